// File: rtl/hmmm_pkg.sv
// Shared arbiter definitions: bus widths and the read-owner encoding.
package hmmm_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a fetch request was refused;
// force_if tells the arbiter to hand the next cycle to fetch.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (if_req && !if_gnt) begin
            cnt <= sat_inc(cnt);
        end else begin
            cnt <= '0;
        end
    end

    assign force_if = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with one-cycle read latency.
// Define ARB_STARVE_GUARD_EN to compile in the fetch starvation guard.
module mem_arbiter
    import hmmm_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic       force_if;
    logic       if_win;
    arb_owner_t rd_owner_p1;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .force_if(force_if)
    );
`else
    // Without the guard data has strict priority; a legal limit never forces.
    assign force_if = (STARVE_LIMIT > 15);
`endif

    // Grant stage: combinational decision, blocked outright while reset is high.
    assign if_win = if_req && (!d_req || force_if);
    assign if_gnt = !reset && if_win;
    assign d_gnt  = !reset && d_req && !if_win;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Response stage: remember who owns the read returning next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_p1 <= OWN_NONE;
        end else if (if_gnt) begin
            rd_owner_p1 <= OWN_IF;
        end else if (d_gnt && !d_we) begin
            rd_owner_p1 <= OWN_D;
        end else begin
            rd_owner_p1 <= OWN_NONE;
        end
    end

    assign if_rvalid = (rd_owner_p1 == OWN_IF);
    assign d_rvalid  = (rd_owner_p1 == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, consecutive denied fetch cycles before fetch is forced a grant (legal 1..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port if_addr, input, 8, fetch word address.
REQ-006 SHALL have port if_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid / if_rdata, output, 1 / 16, fetch read data valid / value.
REQ-008 SHALL have port d_req / d_we, input, 1 / 1, data-side request / write-not-read.
REQ-009 SHALL have port d_addr / d_wdata, input, 8 / 16, data address / write data.
REQ-010 SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-011 SHALL have port d_rvalid / d_rdata, output, 1 / 16, data read valid / value.
REQ-012 SHALL have port mem_en / mem_we, output, 1 / 1, single-port RAM enable / write strobe.
REQ-013 SHALL have port mem_addr / mem_wdata, output, 8 / 16, RAM address / write data.
REQ-014 SHALL have port mem_rdata, input, 16, RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 SHALL issue at most one RAM access per cycle; grant is combinational from current-cycle requests.
REQ-016 SHALL grant data over fetch when both request, unless starvation override (REQ-021) is active.
REQ-017 SHALL drive mem_en=1 and route granted requester's addr/we/wdata to RAM in grant cycle; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-018 SHALL assert owner's rvalid exactly one cycle after a read grant, rdata = mem_rdata; other rvalid 0; rdata = 0 when rvalid low.
REQ-019 SHALL produce no rvalid for a data write.
REQ-020 SHALL require requesters to hold req/addr/we/wdata stable until gnt; back-to-back grants to the same requester on consecutive cycles are legal (full throughput).
REQ-021 SHALL keep a saturating starve counter: +1 when if_req && !if_gnt, saturate at STARVE_LIMIT, clear when if_gnt or !if_req; when counter == STARVE_LIMIT and if_req, fetch wins.
REQ-022 SHALL be free of deadlock: any held request is granted within STARVE_LIMIT+1 cycles (guard compiled in).

Reset
REQ-023 SHALL, while reset high, force if_gnt=0, d_gnt=0, mem_en=0, mem_we=0, regardless of requests.
REQ-024 SHALL reset if_rvalid=0, d_rvalid=0, rdata outputs 0, starve counter 0, read-owner register none.
REQ-025 SHALL discard a read pending across reset assertion: no rvalid after reset deasserts.

Configuration
REQ-026 SHALL compile starvation guard only when ARB_STARVE_GUARD_EN is defined; without it, no counter is instantiated and data has strict priority (fetch may starve indefinitely); STARVE_LIMIT then unused.

Structure
REQ-027 SHALL take from shared package hmmm_pkg: ADDR_W=8, DATA_W=16, enum arb_owner_t {OWN_NONE, OWN_IF, OWN_D}.
REQ-028 SHALL place the starve counter in sub-module arb_starve_ctr (inputs clk, reset, if_req, if_gnt; output force_if).

Verification
REQ-029 SHALL cover: only if_req, if_addr=0x04, mem_rdata=0x1A2B next cycle -> cycle0 if_gnt=1, mem_addr=0x04; cycle1 if_rvalid=1, if_rdata=0x1A2B, d_rvalid=0.
REQ-030 SHALL cover: if_req and d_req read d_addr=0x10 same cycle, guard on -> d_gnt=1, if_gnt=0, mem_addr=0x10; counter=1; cycle1 d_rvalid=1.
REQ-031 SHALL cover: both held continuously, STARVE_LIMIT=3, guard on -> d_gnt cycles 0-2, if_gnt cycle 3, counter 0 after; d_gnt cycle 4.
REQ-032 SHALL cover: d write d_addr=0x20 d_wdata=0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0xBEEF; no d_rvalid next cycle.
REQ-033 SHALL cover: reset asserted mid-cycle after fetch read grant -> if_rvalid stays 0 through and after reset; counter 0.
REQ-034 SHALL cover: ARB_STARVE_GUARD_EN undefined, both requests held 10 cycles -> d_gnt all 10 cycles, if_gnt never.
